// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - state encoding and mode constants for the LED blink sequencer
package led_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ON   = 3'd1,
        ST_OFF  = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_CONT    = 1'b1;

endpackage

// File: rtl/seq_down_counter.sv
// rtl/seq_down_counter.sv - phase down-counter loading max(value,1)-1 with zero flag
module seq_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // A zero phase time still lasts one cycle, so it loads 0 rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= (value == '0) ? '0 : value - W'(1);
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/led_blink_sequencer.sv
// rtl/led_blink_sequencer.sv - ON/OFF/GAP LED burst sequencer with one-shot and continuous modes
module led_blink_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_LED = 4,
    parameter int CNT_W = 16,
    parameter int REP_W = 4
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             start_in,
    input  logic             stop_in,
    input  logic             mode_in,
    input  logic [CNT_W-1:0] on_time_in,
    input  logic [CNT_W-1:0] off_time_in,
    input  logic [CNT_W-1:0] idle_time_in,
    input  logic [REP_W-1:0] blink_count_in,
    input  logic [N_LED-1:0] chan_mask_in,
    output logic [N_LED-1:0] led_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [2:0]       state_out
);

    state_t             state, next_state;
    logic               mode_snap;
    logic [CNT_W-1:0]   on_snap, off_snap, idle_snap;
    logic [REP_W-1:0]   count_snap, rem, rem_next;
    logic [N_LED-1:0]   mask_snap;
    logic               snap_en;
    logic               cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]   cnt_value;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state      <= ST_IDLE;
            mode_snap  <= MODE_ONESHOT;
            on_snap    <= '0;
            off_snap   <= '0;
            idle_snap  <= '0;
            count_snap <= '0;
            mask_snap  <= '0;
            rem        <= '0;
        end else begin
            state <= next_state;
            rem   <= rem_next;
            if (snap_en) begin
                mode_snap  <= mode_in;
                on_snap    <= on_time_in;
                off_snap   <= off_time_in;
                idle_snap  <= idle_time_in;
                count_snap <= blink_count_in;
                mask_snap  <= chan_mask_in;
            end
        end
    end

    seq_down_counter #(.W(CNT_W)) u_phase_cnt (
        .clk   (clock_in),
        .rst   (reset_in),
        .load  (cnt_load),
        .value (cnt_value),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

    // Stop is checked first in every active state so it beats a phase exit.
    always_comb begin
        next_state = state;
        snap_en    = 1'b0;
        cnt_load   = 1'b0;
        cnt_value  = '0;
        cnt_dec    = 1'b0;
        rem_next   = rem;
        case (state)
            ST_IDLE: begin
                if (start_in && !stop_in) begin
                    snap_en  = 1'b1;
                    rem_next = blink_count_in;
                    if (blink_count_in == '0) begin
                        next_state = (mode_in == MODE_ONESHOT) ? ST_DONE : ST_IDLE;
                    end else begin
                        next_state = ST_ON;
                        cnt_load   = 1'b1;
                        cnt_value  = on_time_in;
                    end
                end
            end
            ST_ON: begin
                if (stop_in) begin
                    next_state = ST_IDLE;
                end else if (cnt_zero) begin
                    rem_next = rem - REP_W'(1);
                    cnt_load = 1'b1;
                    if (rem == REP_W'(1)) begin
                        next_state = ST_GAP;
                        cnt_value  = idle_snap;
                    end else begin
                        next_state = ST_OFF;
                        cnt_value  = off_snap;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_OFF: begin
                if (stop_in) begin
                    next_state = ST_IDLE;
                end else if (cnt_zero) begin
                    next_state = ST_ON;
                    cnt_load   = 1'b1;
                    cnt_value  = on_snap;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (stop_in) begin
                    next_state = ST_IDLE;
                end else if (cnt_zero) begin
                    if (mode_snap == MODE_CONT) begin
                        next_state = ST_ON;
                        rem_next   = count_snap;
                        cnt_load   = 1'b1;
                        cnt_value  = on_snap;
                    end else begin
                        next_state = ST_DONE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        led_out   = '0;
        busy_out  = 1'b0;
        done_out  = 1'b0;
        state_out = 3'd0;
        case (state)
            ST_IDLE: state_out = ST_IDLE;
            ST_ON: begin
                led_out   = mask_snap;
                busy_out  = 1'b1;
                state_out = ST_ON;
            end
            ST_OFF: begin
                busy_out  = 1'b1;
                state_out = ST_OFF;
            end
            ST_GAP: begin
                busy_out  = 1'b1;
                state_out = ST_GAP;
            end
            ST_DONE: begin
                done_out  = 1'b1;
                state_out = ST_DONE;
            end
            default: state_out = 3'd0;
        endcase
    end

endmodule

// File: tb/tb_led_blink_sequencer.sv
// tb/tb_led_blink_sequencer.sv - self-checking bench for led_blink_sequencer against a timeline model
module tb_led_blink_sequencer;

    localparam int N_LED = 4;
    localparam int CNT_W = 16;
    localparam int REP_W = 4;

    logic             clock_in = 1'b0;
    logic             reset_in, start_in, stop_in, mode_in;
    logic [CNT_W-1:0] on_time_in, off_time_in, idle_time_in;
    logic [REP_W-1:0] blink_count_in;
    logic [N_LED-1:0] chan_mask_in;
    logic [N_LED-1:0] led_out;
    logic             busy_out, done_out;
    logic [2:0]       state_out;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    led_blink_sequencer #(.N_LED(N_LED), .CNT_W(CNT_W), .REP_W(REP_W)) dut (
        .clock_in       (clock_in),
        .reset_in       (reset_in),
        .start_in       (start_in),
        .stop_in        (stop_in),
        .mode_in        (mode_in),
        .on_time_in     (on_time_in),
        .off_time_in    (off_time_in),
        .idle_time_in   (idle_time_in),
        .blink_count_in (blink_count_in),
        .chan_mask_in   (chan_mask_in),
        .led_out        (led_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .state_out      (state_out)
    );

    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    function automatic int tmax(input int t);
        return (t == 0) ? 1 : t;
    endfunction

    // Expected per-cycle state (0 IDLE,1 ON,2 OFF,3 GAP,4 DONE) for cycles 1..len after start.
    task automatic build(input int on, input int off, input int idle, input int cnt,
                         input int mode, input int hold, input int len);
        exp_q.delete();
        while (exp_q.size() < len) begin
            for (int b = 1; b <= cnt; b++) begin
                repeat (tmax(on)) exp_q.push_back(1);
                if (b < cnt) repeat (tmax(off)) exp_q.push_back(2);
            end
            if (cnt > 0) repeat (tmax(idle)) exp_q.push_back(3);
            if (mode == 0) begin
                exp_q.push_back(4);
                if (hold == 0) break;
                exp_q.push_back(0);
            end else if (cnt == 0) begin
                exp_q.push_back(0);
            end
        end
        while (exp_q.size() < len) exp_q.push_back(0);
    endtask

    task automatic check_cycle(input string tag, input int e, input logic [N_LED-1:0] mask);
        check({tag, " state"}, 32'(state_out), 32'(e));
        check({tag, " led"},   32'(led_out),   (e == 1) ? 32'(mask) : 32'd0);
        check({tag, " busy"},  32'(busy_out),  (e >= 1 && e <= 3) ? 32'd1 : 32'd0);
        check({tag, " done"},  32'(done_out),  (e == 4) ? 32'd1 : 32'd0);
    endtask

    task automatic run_burst(input string tag, input int on, input int off, input int idle,
                             input int cnt, input int mode, input logic [N_LED-1:0] mask,
                             input int len, input int stop_at, input int hold);
        int stopped;
        int e;
        build(on, off, idle, cnt, mode, hold, len);
        on_time_in     = CNT_W'(on);
        off_time_in    = CNT_W'(off);
        idle_time_in   = CNT_W'(idle);
        blink_count_in = REP_W'(cnt);
        mode_in        = mode[0];
        chan_mask_in   = mask;
        stop_in        = 1'b0;
        start_in       = 1'b1;
        step();
        if (hold == 0) start_in = 1'b0;
        stopped = 0;
        for (int k = 1; k <= len; k++) begin
            e = stopped ? 0 : exp_q[k-1];
            check_cycle($sformatf("%s c%0d", tag, k), e, mask);
            if (hold == 0) begin
                on_time_in     = CNT_W'($urandom_range(0, 6));
                off_time_in    = CNT_W'($urandom_range(0, 6));
                idle_time_in   = CNT_W'($urandom_range(0, 6));
                blink_count_in = REP_W'($urandom);
                mode_in        = 1'($urandom);
                chan_mask_in   = N_LED'($urandom);
            end
            if (k == stop_at) begin
                stop_in = 1'b1;
                stopped = 1;
            end
            step();
            stop_in = 1'b0;
        end
        start_in = 1'b0;
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
        check({tag, " post-reset state"}, 32'(state_out), 32'd0);
    endtask

    initial begin
        reset_in = 1'b1;
        start_in = 1'b0;
        stop_in = 1'b0;
        mode_in = 1'b0;
        on_time_in = '0;
        off_time_in = '0;
        idle_time_in = '0;
        blink_count_in = '0;
        chan_mask_in = '0;
        step();
        step();
        reset_in = 1'b0;
        check_cycle("reset", 0, 4'b0000);

        run_burst("nominal", 3, 2, 4, 2, 0, 4'b0101, 15, 0, 0);
        run_burst("zero_times", 0, 0, 0, 3, 0, 4'b1111, 9, 0, 0);
        run_burst("continuous", 2, 1, 2, 1, 1, 4'b1010, 12, 9, 0);

        start_in = 1'b1;
        stop_in = 1'b1;
        blink_count_in = 4'd2;
        step();
        check("start+stop state", 32'(state_out), 32'd0);
        check("start+stop led", 32'(led_out), 32'd0);
        start_in = 1'b0;
        stop_in = 1'b0;
        run_burst("stop_mid_on", 5, 1, 1, 2, 0, 4'b0011, 6, 2, 0);

        on_time_in = 16'd2;
        off_time_in = 16'd3;
        idle_time_in = 16'd1;
        blink_count_in = 4'd2;
        mode_in = 1'b0;
        chan_mask_in = 4'b1111;
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        check("rst c1 state", 32'(state_out), 32'd1);
        step();
        step();
        check("rst c3 state", 32'(state_out), 32'd2);
        reset_in = 1'b1;
        start_in = 1'b1;
        stop_in = 1'b0;
        step();
        check_cycle("mid_reset", 0, 4'b0000);
        reset_in = 1'b0;
        start_in = 1'b0;
        step();
        check("after reset state", 32'(state_out), 32'd0);

        run_burst("cnt0_oneshot", 2, 2, 2, 0, 0, 4'b1111, 4, 0, 0);
        run_burst("cnt0_cont", 2, 2, 2, 0, 1, 4'b1111, 4, 0, 0);
        run_burst("hold_start", 1, 1, 1, 1, 0, 4'b1001, 10, 0, 1);

        for (int i = 0; i < 15; i++) begin
            run_burst($sformatf("rand%0d", i),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 1)), 4'($urandom),
                      30, int'($urandom_range(0, 25)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_blink_sequencer.md
Name: led_blink_sequencer

Overview:
Parametrised LED blink sequencer. It drives a group of N_LED outputs through a programmable pattern: ON, OFF, repeat, then an idle GAP. Phase timers and the blink counter are internal, so no external timer handshakes are needed. One-shot and continuous modes are supported. The block sits between the register/config front end and the board LED pins.

Parameters:
N_LED, 4, number of LED outputs driven in parallel
CNT_W, 16, width of the on/off/idle phase time fields in clock cycles
REP_W, 4, width of the blink count field

Ports:
clock_in  input  1  system clock
reset_in  input  1  synchronous active-high reset
start_in  input  1  start request, sampled only in IDLE
stop_in  input  1  abort request, sampled in every state
mode_in  input  1  0 = one-shot, 1 = continuous; snapshotted at start
on_time_in  input  CNT_W  ON phase length in cycles
off_time_in  input  CNT_W  OFF phase length in cycles
idle_time_in  input  CNT_W  GAP phase length in cycles
blink_count_in  input  REP_W  number of ON pulses per burst
chan_mask_in  input  N_LED  LEDs that participate
led_out  output  N_LED  LED drive
busy_out  output  1  high in ON, OFF and GAP
done_out  output  1  one-cycle pulse at burst completion (one-shot only)
state_out  output  3  current state encoding, for debug

Behaviour:
- Interface: one clock (clock_in); reset_in is synchronous and active-high.
- Reset: state = IDLE. led_out = 0, busy_out = 0, done_out = 0, state_out = IDLE. Snapshot registers, phase counter and remaining-blink counter are all cleared.
- Outputs are a Moore decode of the state register:
  - led_out = mask_snap in ON, 0 in every other state.
- States and encodings: IDLE = 0, ON = 1, OFF = 2, GAP = 3, DONE = 4. Other encodings go to IDLE next cycle with all outputs 0.
- Start (IDLE, start_in = 1, stop_in = 0):
  - Snapshot mode, the three times, blink_count and mask.
  - rem = blink_count.
  - If blink_count == 0, go to DONE in one-shot mode, or stay in IDLE in continuous mode.
  - Otherwise go to ON. led_out is visible the cycle after the sampling edge.
- Phase timing:
  - Each phase lasts exactly max(time, 1) cycles; a time value of 0 is treated as 1.
  - The counter loads max(time, 1) - 1 on phase entry and counts down to 0. The phase exits on the edge where the counter reads 0.
- Transitions:
  - ON exit: rem decrements. If rem becomes 0, go to GAP; otherwise go to OFF.
  - OFF exit: go to ON.
  - GAP exit, continuous mode: reload rem from the snapshot and go to ON.
  - GAP exit, one-shot mode: go to DONE.
  - DONE lasts one cycle with done_out = 1 and busy_out = 0, then goes to IDLE.
- stop_in = 1 in any non-IDLE state: go to IDLE next cycle, led_out = 0, no done pulse.
  - stop_in has priority over start_in and over phase exit.
- Input changes while not IDLE are ignored until the next start.
- start_in held high continuously: a new burst begins the cycle after DONE returns to IDLE (IDLE lasts one cycle).
- Counter widths: the phase counter is CNT_W bits and rem is REP_W bits. Neither wraps, because both are loaded before they are decremented.
- Reset asserted mid-burst: IDLE on the next edge, regardless of stop_in or start_in.

Decomposition:
- Package led_seq_pkg holds:
  - state encoding localparams (width 3);
  - the MODE_ONESHOT and MODE_CONT constants.
- One sub-module, seq_down_counter (parameter W). It provides:
  - a load with max(value, 1) - 1;
  - a decrement enable;
  - a zero flag output.
- A single instance of seq_down_counter is shared by all three phases.

Test Plan:
1. Nominal one-shot burst.
   - Stimulus: N_LED = 4, on = 3, off = 2, idle = 4, count = 2, mode = 0, mask = 0101, start at edge 0.
   - Response: led_out = 0101 in cycles 1-3, 0 in cycles 4-5, 0101 in cycles 6-8, 0 in GAP cycles 9-12. done_out = 1 only in cycle 13. IDLE in cycle 14. busy_out = 1 in cycles 1-12.
2. Zero-time phases.
   - Stimulus: on = 0, off = 0, idle = 0, count = 3, mode = 0.
   - Response: ON/OFF alternate every cycle (ON 1, OFF 2, ON 3, OFF 4, ON 5), GAP in cycle 6, done in cycle 7.
3. Continuous mode.
   - Stimulus: on = 2, off = 1, idle = 2, count = 1, mode = 1.
   - Response: repeating ON, ON, GAP, GAP pattern with a period of 4 cycles; done_out never asserts. stop_in in cycle 9 gives led_out = 0 and IDLE from cycle 10.
4. Stop and start priority.
   - Stimulus: start_in and stop_in both high in IDLE.
   - Response: stays in IDLE. stop_in pulsed mid-ON gives IDLE next cycle with no done pulse.
5. Mid-burst reset.
   - Stimulus: reset_in pulsed high in an OFF cycle.
   - Response: all outputs are 0 and state_out = 0 on the next cycle. Input changes during the burst do not alter its timing.
6. blink_count = 0.
   - Stimulus: one-shot mode.
   - Response: done_out pulses the cycle after start and led_out stays 0.
   - Stimulus: continuous mode.
   - Response: the block stays in IDLE.
